rtu_rob: RTL and testbench

- Parametrised reorder buffer: a circular queue of DEPTH entries in the RTU.
- Allocates one instruction per cycle in program order and accepts out-of-order completion on CPL_PORTS ports, indexed by IID.
- Retires up to RETIRE_W consecutive completed entries per cycle from the head.
- Raises a one-cycle flush/jump pulse after a redirecting instruction (bju or ras) retires.

---
 rtl/rtu_rob_pkg.sv | 30 +++
 rtl/rtu_rob_if.sv | 54 +++++
 rtl/rtu_rob_retire_sel.sv | 43 ++++
 rtl/rtu_rob.sv | 161 ++++++++++++++++
 tb/tb_rtu_rob.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/rtu_rob_pkg.sv
// Shared types and helpers for the RTU reorder buffer.
package rtu_rob_pkg;

    localparam int DEF_DEPTH    = 16;
    localparam int DEF_RETIRE_W = 2;
    localparam int DEF_PREG_W   = 6;
    localparam int DEF_PC_W     = 64;
    localparam int MAX_RW       = 4;

    typedef struct packed {
        logic                  vld;
        logic                  complete;
        logic                  bju;
        logic                  ras;
        logic [DEF_PC_W-1:0]   pc;
        logic                  dst_vld;
        logic [4:0]            dst;
        logic [DEF_PREG_W-1:0] pdst;
    } rob_entry_t;

    function automatic logic [2:0] popcount(input logic [MAX_RW-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < MAX_RW; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/rtu_rob_if.sv
// Allocation, completion and retire bundle of the reorder buffer.
interface rtu_rob_if #(
    parameter int DEPTH     = 16,
    parameter int RETIRE_W  = 2,
    parameter int CPL_PORTS = 2,
    parameter int PC_W      = 64,
    parameter int PREG_W    = 6,
    parameter int IID_W     = $clog2(DEPTH)
);
    logic                       create_vld;
    logic [PC_W-1:0]            create_pc;
    logic                       create_dst_vld;
    logic [4:0]                 create_dst;
    logic [PREG_W-1:0]          create_pdst;
    logic                       create_ras;
    logic                       create_rdy;
    logic [IID_W-1:0]           create_iid;
    logic [CPL_PORTS-1:0]       cpl_vld;
    logic [CPL_PORTS*IID_W-1:0] cpl_iid;
    logic [CPL_PORTS-1:0]       cpl_bju;
    logic                       rtu_global_flush;
    logic [RETIRE_W-1:0]        retire_vld;
    logic [RETIRE_W*PC_W-1:0]   retire_pc;
    logic [RETIRE_W-1:0]        retire_dst_vld;
    logic [RETIRE_W*5-1:0]      retire_dst;
    logic [RETIRE_W*PREG_W-1:0] retire_pdst;
    logic                       flush_vld;
    logic                       jump_vld;
    logic                       empty;
    logic [IID_W:0]             entry_cnt;

    modport slave (
        input  create_vld, create_pc, create_dst_vld,
        input  create_dst, create_pdst, create_ras,
        output create_rdy, create_iid,
        input  cpl_vld, cpl_iid, cpl_bju,
        input  rtu_global_flush,
        output retire_vld, retire_pc, retire_dst_vld,
        output retire_dst, retire_pdst,
        output flush_vld, jump_vld, empty, entry_cnt
    );

    modport master (
        output create_vld, create_pc, create_dst_vld,
        output create_dst, create_pdst, create_ras,
        input  create_rdy, create_iid,
        output cpl_vld, cpl_iid, cpl_bju,
        output rtu_global_flush,
        input  retire_vld, retire_pc, retire_dst_vld,
        input  retire_dst, retire_pdst,
        input  flush_vld, jump_vld, empty, entry_cnt
    );

endinterface

// File: rtl/rtu_rob_retire_sel.sv
// Picks the in-order run of retirable head slots, stopping at a redirect.
module rtu_rob_retire_sel
    import rtu_rob_pkg::*;
#(
    parameter int RETIRE_W = DEF_RETIRE_W
) (
    input  logic                i_block,
    input  logic [RETIRE_W-1:0] i_vld,
    input  logic [RETIRE_W-1:0] i_cpl,
    input  logic [RETIRE_W-1:0] i_redir,
    output logic [RETIRE_W-1:0] o_retire_vld,
    output logic                o_redirect_hit,
    output logic [2:0]          o_retire_num
);

    logic              w_go;
    logic [MAX_RW-1:0] w_pad;

    // w_go drops at the first non-retirable slot or after a redirect
    always_comb begin
        o_retire_vld   = '0;
        o_redirect_hit = 1'b0;
        w_go           = ~i_block;
        for (int k = 0; k < RETIRE_W; k++) begin
            if (w_go && i_vld[k] && i_cpl[k]) begin
                o_retire_vld[k] = 1'b1;
                if (i_redir[k]) begin
                    o_redirect_hit = 1'b1;
                    w_go           = 1'b0;
                end
            end else begin
                w_go = 1'b0;
            end
        end
    end

    always_comb begin
        w_pad                 = '0;
        w_pad[RETIRE_W-1:0]   = o_retire_vld;
        o_retire_num          = popcount(w_pad);
    end

endmodule

// File: rtl/rtu_rob.sv
// Reorder buffer: in-order allocate, out-of-order complete,
// multi-slot in-order retire with redirect flush pulse.
module rtu_rob
    import rtu_rob_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int RETIRE_W  = DEF_RETIRE_W,
    parameter int CPL_PORTS = 2,
    parameter int PC_W      = DEF_PC_W,
    parameter int PREG_W    = DEF_PREG_W,
    parameter int IID_W     = $clog2(DEPTH)
) (
    input logic     clk,
    input logic     rst_clk,
    rtu_rob_if.slave bus
);

    typedef logic [IID_W:0] ptr_t;

    rob_entry_t r_ent     [DEPTH];
    rob_entry_t w_ent_nxt [DEPTH];
    ptr_t       r_head;
    ptr_t       r_tail;
    logic       r_flush;

    logic                w_full;
    logic                w_block;
    logic                w_create;
    logic [DEPTH-1:0]    w_cpl_hit;
    logic [DEPTH-1:0]    w_bju_hit;
    logic [IID_W-1:0]    w_slot_idx [RETIRE_W];
    logic [RETIRE_W-1:0] w_s_vld;
    logic [RETIRE_W-1:0] w_s_cpl;
    logic [RETIRE_W-1:0] w_s_redir;
    logic [RETIRE_W-1:0] w_ret_vld;
    logic                w_redir_hit;
    logic [2:0]          w_ret_num;
    logic [IID_W-1:0]    w_tail_idx;
    logic [IID_W-1:0]    w_ciid;

    assign w_tail_idx = r_tail[IID_W-1:0];
    assign w_full     = (r_head[IID_W-1:0] == w_tail_idx)
                      && (r_head[IID_W] != r_tail[IID_W]);
    assign w_block    = r_flush | bus.rtu_global_flush;
    assign w_create   = bus.create_vld & bus.create_rdy;

    // Per-entry completion strobes, ORed across ports
    always_comb begin
        w_cpl_hit = '0;
        w_bju_hit = '0;
        w_ciid    = '0;
        for (int p = 0; p < CPL_PORTS; p++) begin
            w_ciid = bus.cpl_iid[p*IID_W +: IID_W];
            if (bus.cpl_vld[p]) begin
                w_cpl_hit[w_ciid] = 1'b1;
                if (bus.cpl_bju[p]) begin
                    w_bju_hit[w_ciid] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < RETIRE_W; k++) begin
            w_slot_idx[k] = r_head[IID_W-1:0] + IID_W'(k);
            w_s_vld[k]    = r_ent[w_slot_idx[k]].vld;
            w_s_cpl[k]    = r_ent[w_slot_idx[k]].complete
                          | w_cpl_hit[w_slot_idx[k]];
            w_s_redir[k]  = r_ent[w_slot_idx[k]].bju
                          | r_ent[w_slot_idx[k]].ras
                          | w_bju_hit[w_slot_idx[k]];
        end
    end

    rtu_rob_retire_sel #(
        .RETIRE_W (RETIRE_W)
    ) u_sel (
        .i_block        (w_block),
        .i_vld          (w_s_vld),
        .i_cpl          (w_s_cpl),
        .i_redir        (w_s_redir),
        .o_retire_vld   (w_ret_vld),
        .o_redirect_hit (w_redir_hit),
        .o_retire_num   (w_ret_num)
    );

    // Retire clears after completion so a bypassed bit is not left set
    always_comb begin
        w_ent_nxt = r_ent;
        if (w_block) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_ent_nxt[i] = '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_ent[i].vld && w_cpl_hit[i]) begin
                    w_ent_nxt[i].complete = 1'b1;
                    w_ent_nxt[i].bju      = r_ent[i].bju | w_bju_hit[i];
                end
            end
            for (int k = 0; k < RETIRE_W; k++) begin
                if (w_ret_vld[k]) begin
                    w_ent_nxt[w_slot_idx[k]] = '0;
                end
            end
            if (w_create) begin
                w_ent_nxt[w_tail_idx].vld      = 1'b1;
                w_ent_nxt[w_tail_idx].complete = 1'b0;
                w_ent_nxt[w_tail_idx].bju      = 1'b0;
                w_ent_nxt[w_tail_idx].ras      = bus.create_ras;
                w_ent_nxt[w_tail_idx].pc       = bus.create_pc;
                w_ent_nxt[w_tail_idx].dst_vld  = bus.create_dst_vld;
                w_ent_nxt[w_tail_idx].dst      = bus.create_dst;
                w_ent_nxt[w_tail_idx].pdst     =
                    (bus.create_dst == 5'd0) ? '0 : bus.create_pdst;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_clk) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_flush <= 1'b0;
        end else begin
            r_ent   <= w_ent_nxt;
            r_flush <= w_redir_hit;
            if (w_block) begin
                r_tail <= r_head;
            end else begin
                r_head <= r_head + ptr_t'(w_ret_num);
                r_tail <= r_tail + ptr_t'(w_create);
            end
        end
    end

    always_comb begin
        bus.retire_pc      = '0;
        bus.retire_dst_vld = '0;
        bus.retire_dst     = '0;
        bus.retire_pdst    = '0;
        for (int k = 0; k < RETIRE_W; k++) begin
            bus.retire_pc[k*PC_W +: PC_W]       = r_ent[w_slot_idx[k]].pc;
            bus.retire_dst_vld[k]               = r_ent[w_slot_idx[k]].dst_vld;
            bus.retire_dst[k*5 +: 5]            = r_ent[w_slot_idx[k]].dst;
            bus.retire_pdst[k*PREG_W +: PREG_W] = r_ent[w_slot_idx[k]].pdst;
        end
    end

    assign bus.retire_vld = w_ret_vld;
    assign bus.create_rdy = ~w_full & ~w_block;
    assign bus.create_iid = w_tail_idx;
    assign bus.flush_vld  = r_flush;
    assign bus.jump_vld   = r_flush;
    assign bus.empty      = (r_head == r_tail);
    assign bus.entry_cnt  = r_tail - r_head;

endmodule

// File: tb/tb_rtu_rob.sv
// Directed table-driven bench for the reorder buffer.
module tb_rtu_rob;

    localparam int DEPTH = 16;
    localparam int RW    = 2;
    localparam int CP    = 2;
    localparam int PC_W  = 64;
    localparam int PW    = 6;
    localparam int IW    = 4;

    typedef struct {
        logic       rst;
        logic       cv;
        logic [4:0] cdst;
        logic [5:0] cpdst;
        logic       cras;
        logic [1:0] cplv;
        logic [3:0] ci0;
        logic [3:0] ci1;
        logic [1:0] cbju;
        logic       gf;
        logic [1:0] rv;
        logic       rdy;
        logic [3:0] iid;
        logic [4:0] cnt;
        logic       fl;
        logic [5:0] pd0;
        logic [5:0] pd1;
    } vec_t;

    logic clk;
    logic rst_clk;
    vec_t tv[$];
    int   checks;
    int   errors;

    rtu_rob_if #(
        .DEPTH(DEPTH), .RETIRE_W(RW), .CPL_PORTS(CP),
        .PC_W(PC_W), .PREG_W(PW)
    ) bus ();

    rtu_rob #(
        .DEPTH(DEPTH), .RETIRE_W(RW), .CPL_PORTS(CP),
        .PC_W(PC_W), .PREG_W(PW)
    ) dut (
        .clk     (clk),
        .rst_clk (rst_clk),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int row,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d actual=%h required=%h",
                     nm, row, act, exp);
        end
    endtask

    task automatic add(
        input logic rst, input logic cv, input logic [4:0] cdst,
        input logic [5:0] cpdst, input logic cras,
        input logic [1:0] cplv, input logic [3:0] ci0,
        input logic [3:0] ci1, input logic [1:0] cbju, input logic gf,
        input logic [1:0] rv, input logic rdy, input logic [3:0] iid,
        input logic [4:0] cnt, input logic fl,
        input logic [5:0] pd0, input logic [5:0] pd1);
        vec_t v;
        v.rst = rst; v.cv = cv; v.cdst = cdst; v.cpdst = cpdst;
        v.cras = cras; v.cplv = cplv; v.ci0 = ci0; v.ci1 = ci1;
        v.cbju = cbju; v.gf = gf; v.rv = rv; v.rdy = rdy;
        v.iid = iid; v.cnt = cnt; v.fl = fl; v.pd0 = pd0; v.pd1 = pd1;
        tv.push_back(v);
    endtask

    // create row: inputs rst..gf, then expectations rv..pd1
    task automatic cr(input logic [3:0] iid, input logic [4:0] cnt);
        add(0,1,1,2,0, 0,0,0,0,0, 0,1,iid,cnt,0,0,0);
    endtask

    task automatic fill;
        // fill to full, overflow dropped
        for (int i = 0; i < 16; i++) cr(4'(i), 5'(i));
        add(0,1,1,2,0, 0,0,0,0,0, 0,0,0,16,0,0,0);
        add(0,0,0,0,0, 0,0,0,0,0, 0,0,0,16,0,0,0);
        add(1,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0);
        // out-of-order completion
        for (int i = 0; i < 4; i++) cr(4'(i), 5'(i));
        add(0,0,0,0,0, 1,3,0,0,0, 0,1,4,4,0,0,0);
        add(0,0,0,0,0, 1,1,0,0,0, 0,1,4,4,0,0,0);
        add(0,0,0,0,0, 1,0,0,0,0, 3,1,4,4,0,2,2);
        add(0,0,0,0,0, 1,2,0,0,0, 3,1,4,2,0,2,2);
        add(0,0,0,0,0, 0,0,0,0,0, 0,1,4,0,0,0,0);
        // pdst zeroed for dst 0
        add(0,1,0,17,0, 0,0,0,0,0, 0,1,4,0,0,0,0);
        add(0,1,5,9,0,  0,0,0,0,0, 0,1,5,1,0,0,0);
        add(0,0,0,0,0, 3,4,5,0,0, 3,1,6,2,0,0,9);
        add(0,0,0,0,0, 0,0,0,0,0, 0,1,6,0,0,0,0);
        // bju redirect and flush pulse
        cr(6,0); cr(7,1); cr(8,2);
        add(0,0,0,0,0, 3,6,7,1,0, 1,1,9,3,0,2,0);
        add(0,1,1,2,0, 1,7,0,0,0, 0,0,9,2,1,0,0);
        add(0,0,0,0,0, 0,0,0,0,0, 0,1,7,0,0,0,0);
        // walk head to 15 then retire across the wrap
        cr(7,0);
        for (int k = 8; k < 16; k++)
            add(0,1,1,2,0, 1,4'(k-1),0,0,0, 1,1,4'(k),1,0,2,0);
        cr(0,1);
        add(0,0,0,0,0, 3,15,0,0,0, 3,1,1,2,0,2,2);
        add(0,0,0,0,0, 0,0,0,0,0, 0,1,1,0,0,0,0);
        // global flush blocks a pending bju retire
        cr(1,0); cr(2,1);
        add(0,0,0,0,0, 1,1,0,1,1, 0,0,3,2,0,0,0);
        add(0,0,0,0,0, 0,0,0,0,0, 0,1,1,0,0,0,0);
        // global flush in the pulse cycle
        cr(1,0); cr(2,1);
        add(0,0,0,0,0, 1,1,0,1,0, 1,1,3,2,0,2,0);
        add(0,0,0,0,0, 0,0,0,0,1, 0,0,3,1,1,0,0);
        add(0,0,0,0,0, 0,0,0,0,0, 0,1,2,0,0,0,0);
        // reset with live entries
        for (int i = 0; i < 5; i++) cr(4'(i+2), 5'(i));
        add(1,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0);
        add(0,0,0,0,0, 0,0,0,0,0, 0,1,0,0,0,0,0);
        // ras always redirects, younger slot held back
        add(0,1,1,2,1, 0,0,0,0,0, 0,1,0,0,0,0,0);
        cr(1,1);
        add(0,0,0,0,0, 3,0,1,0,0, 1,1,2,2,0,2,0);
        add(0,0,0,0,0, 0,0,0,0,0, 0,0,2,1,1,0,0);
        add(0,0,0,0,0, 0,0,0,0,0, 0,1,1,0,0,0,0);
    endtask

    task automatic idle;
        bus.create_vld       = 1'b0;
        bus.create_pc        = '0;
        bus.create_dst_vld   = 1'b0;
        bus.create_dst       = '0;
        bus.create_pdst      = '0;
        bus.create_ras       = 1'b0;
        bus.cpl_vld          = '0;
        bus.cpl_iid          = '0;
        bus.cpl_bju          = '0;
        bus.rtu_global_flush = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst_clk = 1'b1;
        tick();
        tick();
        rst_clk = 1'b0;
        fill();
        for (int r = 0; r < tv.size(); r++) begin
            rst_clk              = tv[r].rst;
            bus.create_vld       = tv[r].cv;
            bus.create_pc        = 64'h100 + 64'(r * 4);
            bus.create_dst_vld   = 1'b1;
            bus.create_dst       = tv[r].cdst;
            bus.create_pdst      = tv[r].cpdst;
            bus.create_ras       = tv[r].cras;
            bus.cpl_vld          = tv[r].cplv;
            bus.cpl_iid          = {tv[r].ci1, tv[r].ci0};
            bus.cpl_bju          = tv[r].cbju;
            bus.rtu_global_flush = tv[r].gf;
            #1;
            if (!tv[r].rst) begin
                chk("retire_vld", r, 64'(bus.retire_vld), 64'(tv[r].rv));
                chk("create_rdy", r, 64'(bus.create_rdy), 64'(tv[r].rdy));
                chk("create_iid", r, 64'(bus.create_iid), 64'(tv[r].iid));
                chk("entry_cnt", r, 64'(bus.entry_cnt), 64'(tv[r].cnt));
                chk("empty", r, 64'(bus.empty), 64'(tv[r].cnt == 0));
                chk("flush_vld", r, 64'(bus.flush_vld), 64'(tv[r].fl));
                chk("jump_vld", r, 64'(bus.jump_vld), 64'(tv[r].fl));
                if (tv[r].rv[0])
                    chk("pdst0", r, 64'(bus.retire_pdst[5:0]),
                        64'(tv[r].pd0));
                if (tv[r].rv[1])
                    chk("pdst1", r, 64'(bus.retire_pdst[11:6]),
                        64'(tv[r].pd1));
            end
            tick();
        end
        idle();
        rst_clk = 1'b0;
        // head = tail = 1: payload fields and duplicate-IID completion
        bus.create_vld     = 1'b1;
        bus.create_pc      = 64'hDEAD_BEEF_0000_1234;
        bus.create_dst_vld = 1'b1;
        bus.create_dst     = 5'd7;
        bus.create_pdst    = 6'd33;
        #1;
        chk("seq_iid", 900, 64'(bus.create_iid), 64'd1);
        tick();
        idle();
        bus.cpl_vld = 2'b11;
        bus.cpl_iid = {4'd1, 4'd1};
        #1;
        chk("seq_rv", 901, 64'(bus.retire_vld), 64'd1);
        chk("seq_pc", 901, bus.retire_pc[63:0], 64'hDEAD_BEEF_0000_1234);
        chk("seq_dstv", 901, 64'(bus.retire_dst_vld[0]), 64'd1);
        chk("seq_dst", 901, 64'(bus.retire_dst[4:0]), 64'd7);
        chk("seq_pdst", 901, 64'(bus.retire_pdst[5:0]), 64'd33);
        tick();
        idle();
        #1;
        chk("seq_empty", 902, 64'(bus.empty), 64'd1);
        chk("seq_cnt", 902, 64'(bus.entry_cnt), 64'd0);
        chk("seq_iid2", 902, 64'(bus.create_iid), 64'd2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
